// File: rtl/control_sequencer_if.sv
// control_sequencer_if: datapath-side bundle of the control sequencer
// master: sequencer side (receives IR, Mem_ready, Stop; drives strobes, register selects, alu_op, Run, Illegal)
// slave: datapath side (mirror image)
interface control_sequencer_if;
  logic [31:0] IR;
  logic Mem_ready, Stop;
  logic PCout, MDRout, Zlowout, ZHighout, Rout;
  logic MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, IncPC, Read;
  logic Gra, Grb, Grc;
  logic [4:0] alu_op;
  logic Run, Illegal;
  modport master(
    input IR, Mem_ready, Stop,
    output PCout, MDRout, Zlowout, ZHighout, Rout, MARin, PCin, MDRin, IRin, Yin,
           ZLowIn, ZHighIn, HIin, LOin, Rin, IncPC, Read, Gra, Grb, Grc, alu_op, Run, Illegal
  );
  modport slave(
    output IR, Mem_ready, Stop,
    input PCout, MDRout, Zlowout, ZHighout, Rout, MARin, PCin, MDRin, IRin, Yin,
          ZLowIn, ZHighIn, HIin, LOin, Rin, IncPC, Read, Gra, Grb, Grc, alu_op, Run, Illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM issuing fetch/execute datapath strobes one state per clock
// Clock: rising-edge clock; Clear: asynchronous active-high reset
// bus: IR/Mem_ready/Stop in, strobes, Gra/Grb/Grc, alu_op, Run, Illegal out
module control_sequencer (
  input logic Clock,
  input logic Clear,
  control_sequencer_if.master bus
);
  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
  state_t state, nxt, fin_nxt;
  logic [4:0] op;
  logic cls_a, cls_m, cls_u, cls_h, cls_ill, two_op, alu_en, wb;
  // opcode captured leaving T2 so later IR changes cannot alter the running instruction
  always_ff @(posedge Clock or posedge Clear)
    if (Clear) begin
      state <= RST;
      op <= '0;
    end else begin
      state <= nxt;
      if (state == T2) op <= bus.IR[31:27];
    end
  assign cls_a = op inside {[5'd3:5'd11]};
  assign cls_m = op inside {5'd15, 5'd16};
  assign cls_u = op inside {5'd17, 5'd18};
  assign cls_h = op == 5'd27;
  assign cls_ill = !(cls_a || cls_m || cls_u || cls_h || op == 5'd26);
  assign two_op = cls_a || cls_m;
  always_comb begin
    fin_nxt = bus.Stop ? HALT : T0;
    nxt = state;
    case (state)
      RST: nxt = T0;
      T0: nxt = T1;
      T1: nxt = bus.Mem_ready ? T2 : T1;
      T2: nxt = T3;
      T3: nxt = cls_h ? HALT : (two_op || cls_u) ? T4 : fin_nxt;
      T4: nxt = cls_u ? fin_nxt : T5;
      T5: nxt = cls_m ? T6 : fin_nxt;
      T6: nxt = fin_nxt;
      default: nxt = HALT;
    endcase
  end
  assign alu_en = (state == T3 && cls_u) || (state == T4 && two_op);
  assign wb = (state == T5 && cls_a) || (state == T4 && cls_u);
  assign bus.PCout = state == T0;
  assign bus.MARin = state == T0;
  assign bus.IncPC = state == T0;
  assign bus.Read = state == T1;
  assign bus.MDRin = state == T1;
  assign bus.MDRout = state == T2;
  assign bus.IRin = state == T2;
  assign bus.Yin = state == T3 && two_op;
  assign bus.Grb = state == T3 && (two_op || cls_u);
  assign bus.Grc = state == T4 && two_op;
  assign bus.Rout = (state == T3 && (two_op || cls_u)) || (state == T4 && two_op);
  assign bus.ZLowIn = alu_en;
  assign bus.ZHighIn = alu_en;
  assign bus.alu_op = alu_en ? op : 5'd0;
  assign bus.Gra = wb;
  assign bus.Rin = wb;
  assign bus.Zlowout = wb || (state == T5 && cls_m);
  assign bus.LOin = state == T5 && cls_m;
  assign bus.ZHighout = state == T6;
  assign bus.HIin = state == T6;
  assign bus.PCin = 1'b0;
  assign bus.Illegal = state == T3 && cls_ill;
  assign bus.Run = state != RST && state != HALT;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized and directed checks of control_sequencer against a per-instruction strobe-table model
module tb_control_sequencer;
  localparam int PCO = 0, MDRO = 1, ZLO = 2, ZHO = 3, RO = 4, MARI = 5, MDRI = 7, IRI = 8, YI = 9;
  localparam int ZLI = 10, ZHI = 11, HII = 12, LOI = 13, RI = 14, INC = 15, RD = 16, GA = 17, GB = 18, GC = 19;
  localparam int RUN = 20, ILL = 21;
  localparam logic [26:0] ONE = 27'd1;
  localparam logic [26:0] R = ONE << RUN;
  localparam logic [26:0] V_T0 = R | ONE << PCO | ONE << MARI | ONE << INC;
  localparam logic [26:0] V_T1 = R | ONE << RD | ONE << MDRI;
  localparam logic [26:0] V_T2 = R | ONE << MDRO | ONE << IRI;
  localparam logic [26:0] V_GB = R | ONE << GB | ONE << RO;
  localparam logic [26:0] V_ALU = R | ONE << ZLI | ONE << ZHI;
  localparam logic [26:0] V_WB = R | ONE << ZLO | ONE << GA | ONE << RI;
  logic Clock = 0;
  logic Clear = 0;
  control_sequencer_if bus ();
  control_sequencer dut (.Clock(Clock), .Clear(Clear), .bus(bus));
  always #5 Clock = ~Clock;
  int checks = 0, errors = 0, rd_cnt = 0, ill_cnt = 0;
  logic [26:0] exp_v = '0;
  bit exp_valid = 0;
  logic [26:0] q[$];
  logic [4:0] ops[15];
  function automatic logic [26:0] pack();
    return {bus.alu_op, bus.Illegal, bus.Run, bus.Grc, bus.Grb, bus.Gra, bus.Read, bus.IncPC, bus.Rin,
            bus.LOin, bus.HIin, bus.ZHighIn, bus.ZLowIn, bus.Yin, bus.IRin, bus.MDRin, bus.PCin,
            bus.MARin, bus.Rout, bus.ZHighout, bus.Zlowout, bus.MDRout, bus.PCout};
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask
  // 0 A, 1 M, 2 U, 3 nop, 4 halt, 5 illegal
  function automatic int cls(input logic [4:0] op);
    if (op inside {[5'd3:5'd11]}) return 0;
    if (op inside {5'd15, 5'd16}) return 1;
    if (op inside {5'd17, 5'd18}) return 2;
    if (op == 5'd26) return 3;
    if (op == 5'd27) return 4;
    return 5;
  endfunction
  // whole-instruction expected strobe sequence from T0 up to its last executing cycle
  function automatic void build(input logic [4:0] op, input int w);
    logic [26:0] alu;
    alu = 27'(op) << 22;
    q = {};
    q.push_back(V_T0);
    for (int i = 0; i <= w; i++) q.push_back(V_T1);
    q.push_back(V_T2);
    case (cls(op))
      0, 1: begin
        q.push_back(V_GB | ONE << YI);
        q.push_back(R | ONE << GC | ONE << RO | V_ALU | alu);
        if (cls(op) == 0) q.push_back(V_WB);
        else begin
          q.push_back(R | ONE << ZLO | ONE << LOI);
          q.push_back(R | ONE << ZHO | ONE << HII);
        end
      end
      2: begin
        q.push_back(V_GB | V_ALU | alu);
        q.push_back(V_WB);
      end
      5: q.push_back(R | ONE << ILL);
      default: q.push_back(R);
    endcase
  endfunction
  always @(negedge Clock) begin
    if (bus.Read) rd_cnt++;
    if (bus.Illegal) ill_cnt++;
    if (exp_valid) chk("cycle", 32'(pack()), 32'(exp_v));
  end
  task automatic step();
    @(posedge Clock);
    #1;
  endtask
  task automatic idle(input int k);
    exp_v = '0;
    exp_valid = 1;
    repeat (k) begin
      bus.Stop = 1'($urandom);
      bus.Mem_ready = 1'($urandom);
      step();
    end
  endtask
  task automatic do_reset();
    exp_valid = 0;
    Clear = 1;
    #1 chk("clear_zero", 32'(pack()), 0);
    #1 Clear = 0;
    exp_v = '0;
    exp_valid = 1;
    step();
  endtask
  task automatic mid_clear(input logic [26:0] pre);
    exp_valid = 0;
    #1 chk("pre_clear", 32'(pack()), 32'(pre));
    Clear = 1;
    #1 chk("mid_clear_zero", 32'(pack()), 0);
    Clear = 0;
    exp_v = '0;
    exp_valid = 1;
    step();
  endtask
  task automatic do_instr(input logic [31:0] ir, input int w, input bit stop_fin, input bit force_stop,
                          input int abort_at, output bit need_reset);
    int n;
    build(ir[31:27], w);
    n = q.size();
    need_reset = 0;
    for (int i = 0; i < n; i++) begin
      bus.IR = (i >= w + 3) ? $urandom : ir;
      bus.Mem_ready = (i >= 1 && i <= w) ? 1'b0 : (i == w + 1) ? 1'b1 : 1'($urandom);
      bus.Stop = (i == n - 1) ? stop_fin : (force_stop ? 1'b1 : 1'($urandom));
      if (i == abort_at) begin
        mid_clear(q[i]);
        return;
      end
      exp_v = q[i];
      exp_valid = 1;
      step();
    end
    need_reset = stop_fin || cls(ir[31:27]) == 4;
  endtask
  initial begin
    bit nr;
    logic [31:0] ir;
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd27};
    bus.IR = '0;
    bus.Mem_ready = 0;
    bus.Stop = 0;
    step();
    do_reset();
    build(5'd3, 0);
    chk("len_add", q.size(), 6);
    chk("add_t4_vec", 32'(q[4]), 32'h00D80C10);
    build(5'd15, 0);
    chk("len_mul", q.size(), 7);
    build(5'd17, 0);
    chk("len_neg", q.size(), 5);
    build(5'd26, 0);
    chk("len_nop", q.size(), 4);
    build(5'd3, 2);
    chk("len_add_wait2", q.size(), 8);
    do_instr(32'h1A920000, 0, 0, 0, -1, nr);
    chk("add_next_t0", bus.PCout, 1);
    do_instr(32'h78120000, 0, 0, 0, -1, nr);
    chk("mul_next_t0", bus.PCout, 1);
    rd_cnt = 0;
    do_instr(32'h1A920000, 3, 0, 0, -1, nr);
    chk("read_cycles", rd_cnt, 4);
    do_instr(32'h1A920000, 0, 0, 1, -1, nr);
    chk("stop_early_ignored", bus.PCout, 1);
    do_instr(32'h1A920000, 0, 1, 0, -1, nr);
    chk("stop_t5_run", bus.Run, 0);
    idle(3);
    do_reset();
    do_instr(32'hD8000000, 0, 0, 0, -1, nr);
    idle(20);
    chk("halt_run", bus.Run, 0);
    do_reset();
    ill_cnt = 0;
    do_instr(32'hF8000000, 0, 0, 0, -1, nr);
    chk("illegal_pulses", ill_cnt, 1);
    chk("illegal_next_t0", bus.PCout, 1);
    do_instr(32'h1A920000, 0, 0, 0, 4, nr);
    chk("clear_t0", {bus.PCout, bus.MARin, bus.IncPC}, 3'b111);
    for (int k = 0; k < 300; k++) begin
      ir = ($urandom_range(0, 3) == 0) ? $urandom : {ops[$urandom_range(0, 14)], 27'($urandom)};
      do_instr(ir, $urandom_range(0, 3), $urandom_range(0, 7) == 0, 0,
               ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : -1, nr);
      if (nr) begin
        idle(3);
        do_reset();
      end
    end
    exp_valid = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide port Clock, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL provide port Clear, input, 1, asynchronous active-high reset.
REQ-003 SHALL provide port IR, input, 32, instruction register contents from the datapath: opcode IR[31:27], ra IR[26:23], rb IR[22:19], rc IR[18:15].
REQ-004 SHALL provide port Mem_ready, input, 1, memory read-data-valid handshake.
REQ-005 SHALL provide port Stop, input, 1, external halt request.
REQ-006 SHALL provide the following 1-bit datapath strobe outputs: PCout, MDRout, Zlowout, ZHighout, Rout, MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, IncPC, Read.
REQ-007 SHALL provide Gra, Grb and Grc, each output, 1 bit, selecting the ra, rb or rc field for Rin/Rout.
REQ-008 SHALL provide alu_op, output, 5, ALU operation code.
REQ-009 SHALL provide Run, output, 1, meaning that the sequencer is executing instructions.
REQ-010 SHALL provide Illegal, output, 1, one-cycle pulse on an undefined opcode.

Function
REQ-011 SHALL be a Moore FSM, one state per clock; outputs not listed for a state are 0, alu_op = 0 except in ALU states.
REQ-012 States SHALL be: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
REQ-013 RST SHALL assert nothing and go to T0 on the next clock.
REQ-014 T0 SHALL assert PCout, MARin, IncPC, and go to T1.
REQ-015 T1 SHALL assert Read, MDRin; stay in T1 while Mem_ready=0 and go to T2 on the first edge sampling Mem_ready=1.
REQ-016 T2 SHALL assert MDRout, IRin, and go to T3; IR is decoded from T3 onward.
REQ-017 Class A opcodes SHALL be 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol; their sequence is:
- T3: Grb, Rout, Yin;
- T4: Grc, Rout, alu_op=IR[31:27], ZLowIn, ZHighIn;
- T5: Zlowout, Gra, Rin; this is the final state.
REQ-018 Class M opcodes SHALL be 01111 mul and 10000 div; their sequence is:
- T3 and T4 as in Class A;
- T5: Zlowout, LOin;
- T6: ZHighout, HIin; this is the final state.
REQ-019 Class U opcodes SHALL be 10001 neg and 10010 not; their sequence is:
- T3: Grb, Rout, alu_op=IR[31:27], ZLowIn, ZHighIn;
- T4: Zlowout, Gra, Rin; this is the final state.
REQ-020 Opcode 11010 (nop) SHALL assert nothing in T3, and T3 SHALL be final.
REQ-021 Opcode 11011 (halt) SHALL assert nothing in T3 and go to HALT regardless of Stop.
REQ-022 Any other opcode SHALL pulse Illegal for the T3 cycle only and otherwise behave as nop.
REQ-023 From a final state the FSM SHALL go to T0 if Stop=0 and to HALT if Stop=1, with Stop sampled only in final states.
REQ-024 HALT SHALL assert nothing, hold Run=0, and be left only via Clear.
REQ-025 Run SHALL be 1 in T0–T6 and 0 in RST and HALT.
REQ-026 Instruction latency from T0 entry to next T0 entry with Mem_ready=1 in T1 SHALL be: Class A 6, Class M 7, Class U 5, nop/illegal 4 cycles; each T1 wait cycle adds 1.
REQ-027 At most one of Gra/Grb/Grc, and at most one bus driver (PCout, MDRout, Zlowout, ZHighout, Rout), SHALL be 1 in any state.
REQ-028 IR changes outside T2→T3 SHALL NOT affect sequencing beyond the opcode class latched at T3; the class SHALL be held in a register captured on T3 entry.

Reset
REQ-029 Clear=1 SHALL immediately force state RST, all outputs 0, Run=0, Illegal=0, and the latched class cleared, independent of Clock.
REQ-030 Clear asserted mid-instruction (any of T0–T6, including a T1 wait) SHALL abort it; after release, the first rising edge SHALL enter T0.

Verification
REQ-031 The bench SHALL cover add: IR=0x1A920000, Mem_ready=1 → T3 Grb+Rout+Yin, T4 Grc+Rout+alu_op=00011+ZLowIn, T5 Zlowout+Gra+Rin, T0 on cycle 7.
REQ-032 The bench SHALL cover mul: IR=0x78120000 → alu_op=01111 in T4, T5 Zlowout+LOin, T6 ZHighout+HIin, 7-cycle loop.
REQ-033 The bench SHALL cover a memory wait: Mem_ready held 0 for 3 cycles in T1 → Read=MDRin=1 for 4 cycles, IRin one cycle after Mem_ready=1 is sampled.
REQ-034 The bench SHALL cover halt and Stop:
- IR=0xD8000000 → HALT after T3, Run=0, and the state persists for 20 cycles;
- Stop=1 during a Class A T5 → HALT next cycle;
- Stop=1 during T3 of an add → ignored until T5.
REQ-035 The bench SHALL cover an illegal opcode: IR=0xF8000000 → Illegal=1 for exactly one cycle in T3, then T0.
REQ-036 The bench SHALL cover reset mid-operation: Clear pulsed asynchronously (not on an edge) during T4 → outputs 0 within the pulse; after release, RST→T0 with PCout+MARin+IncPC.
